// File: rtl/slv_guard_rst_ctrl_if.sv
// rtl/slv_guard_rst_ctrl_if.sv - guard/subordinate recovery handshake bundle
interface slv_guard_rst_ctrl_if;
  logic timeout_i;
  logic idle_i;
  logic rst_stat_i;
  logic isolate_o;
  logic rst_req_o;
  logic guard_clr_o;

  // Sequencer side: observes guard/subordinate status, drives isolation and reset
  modport master (
    input  timeout_i,
    input  idle_i,
    input  rst_stat_i,
    output isolate_o,
    output rst_req_o,
    output guard_clr_o
  );

  // Environment side: guard and subordinate reset controller
  modport slave (
    output timeout_i,
    output idle_i,
    output rst_stat_i,
    input  isolate_o,
    input  rst_req_o,
    input  guard_clr_o
  );
endinterface

// File: rtl/slv_guard_rst_ctrl.sv
// rtl/slv_guard_rst_ctrl.sv - guard timeout recovery sequencer (isolate, drain, reset, clear)
module slv_guard_rst_ctrl #(
  parameter int CntWidth    = 10,
  parameter int EvtCntWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  slv_guard_rst_ctrl_if.master   bus,
  input  logic                   guard_ena_i,
  input  logic [CntWidth-1:0]    cfg_hold_i,
  input  logic [CntWidth-1:0]    cfg_ack_timeout_i,
  input  logic                   fault_clr_i,
  output logic                   irq_o,
  output logic                   fault_o,
  output logic                   busy_o,
  output logic [EvtCntWidth-1:0] evt_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ASSERT,
    ST_RELEASE,
    ST_CLEAR,
    ST_FAULT
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CntWidth-1:0]   cnt;
  logic                  armed;
  logic                  ack_seen;
  logic [EvtCntWidth-1:0] evt_cnt;

  logic                  limit_hit;
  logic                  hold_met;
  logic                  ack_now;
  logic [CntWidth-1:0]   hold_eff;
  logic [CntWidth:0]     cnt_inc;

  // A zero hold still means one ASSERT cycle; a zero limit disables all timeouts.
  // The current rst_stat_i sample counts as an acknowledge so a one-cycle ASSERT is possible.
  always_comb begin
    hold_eff  = (cfg_hold_i == '0) ? CntWidth'(1) : cfg_hold_i;
    cnt_inc   = {1'b0, cnt} + (CntWidth + 1)'(1);
    hold_met  = (cnt_inc >= {1'b0, hold_eff});
    limit_hit = (cfg_ack_timeout_i != '0) && (cnt == cfg_ack_timeout_i);
    ack_now   = ack_seen | bus.rst_stat_i;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (guard_ena_i && bus.timeout_i && armed) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.idle_i || limit_hit) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (ack_now && hold_met)      state_d = ST_RELEASE;
        else if (!ack_now && limit_hit) state_d = ST_FAULT;
      end
      ST_RELEASE: begin
        if (!bus.rst_stat_i)  state_d = ST_CLEAR;
        else if (limit_hit)   state_d = ST_FAULT;
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_FAULT: begin
        if (fault_clr_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; async reset returns to IDLE so rst_req_o drops immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Per-state dwell counter: restarts on every transition, saturates at all-ones
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  cnt <= '0;
    else if (state_d != state_q) cnt <= '0;
    else if (cnt != '1)         cnt <= cnt + CntWidth'(1);
  end

  // Re-arm only after timeout_i is seen low while IDLE, so a held request cannot loop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                         armed <= 1'b0;
    else if (state_q == ST_IDLE && state_d != ST_IDLE) armed <= 1'b0;
    else if (state_q == ST_IDLE && !bus.timeout_i)     armed <= 1'b1;
  end

  // Sticky reset acknowledge, valid only within one ASSERT visit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   ack_seen <= 1'b0;
    else if (state_q != ST_ASSERT) ack_seen <= 1'b0;
    else if (bus.rst_stat_i)     ack_seen <= 1'b1;
  end

  // Completed-recovery counter, bumped once per CLEAR visit, saturating
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                 evt_cnt <= '0;
    else if (state_q == ST_CLEAR && evt_cnt != '1) evt_cnt <= evt_cnt + EvtCntWidth'(1);
  end

  // Moore output decode; cnt==0 marks the first cycle of a state for the irq pulse
  always_comb begin
    bus.isolate_o   = 1'b0;
    bus.rst_req_o   = 1'b0;
    bus.guard_clr_o = 1'b0;
    irq_o           = 1'b0;
    fault_o         = 1'b0;
    busy_o          = (state_q != ST_IDLE);
    case (state_q)
      ST_DRAIN: begin
        bus.isolate_o = 1'b1;
        irq_o         = (cnt == '0);
      end
      ST_ASSERT: begin
        bus.isolate_o = 1'b1;
        bus.rst_req_o = 1'b1;
      end
      ST_RELEASE: bus.isolate_o = 1'b1;
      ST_CLEAR: begin
        bus.isolate_o   = 1'b1;
        bus.guard_clr_o = 1'b1;
      end
      ST_FAULT: begin
        bus.isolate_o = 1'b1;
        fault_o       = 1'b1;
        irq_o         = (cnt == '0);
      end
      default: ;
    endcase
  end

  assign evt_cnt_o = evt_cnt;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// tb/tb_slv_guard_rst_ctrl.sv - directed bench for slv_guard_rst_ctrl
module tb_slv_guard_rst_ctrl;
  localparam int CW = 10;
  localparam int EW = 2;

  logic          clk;
  logic          rst;
  logic          guard_ena;
  logic [CW-1:0] cfg_hold;
  logic [CW-1:0] cfg_lim;
  logic          fault_clr;
  logic          irq;
  logic          fault;
  logic          busy;
  logic [EW-1:0] evt_cnt;

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;
  int irq0;

  slv_guard_rst_ctrl_if bus ();

  slv_guard_rst_ctrl #(.CntWidth(CW), .EvtCntWidth(EW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .bus              (bus),
    .guard_ena_i      (guard_ena),
    .cfg_hold_i       (cfg_hold),
    .cfg_ack_timeout_i(cfg_lim),
    .fault_clr_i      (fault_clr),
    .irq_o            (irq),
    .fault_o          (fault),
    .busy_o           (busy),
    .evt_cnt_o        (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count irq pulses seen at clock edges
  always @(posedge clk) if (irq === 1'b1) irq_cnt <= irq_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One minimal recovery from IDLE with timeout_i low; ends back in IDLE
  task automatic run_recovery();
    step();
    bus.timeout_i = 1'b1;
    step();
    bus.timeout_i = 1'b0;
    step();
    bus.rst_stat_i = 1'b1;
    step();
    bus.rst_stat_i = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    guard_ena = 1'b1;
    cfg_hold = 4;
    cfg_lim = 20;
    fault_clr = 1'b0;
    bus.timeout_i = 1'b0;
    bus.idle_i = 1'b1;
    bus.rst_stat_i = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_iso", bus.isolate_o, 0);
    chk("rst_req", bus.rst_req_o, 0);
    chk("rst_evt", evt_cnt, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b0;
    step();

    // Nominal recovery
    irq0 = irq_cnt;
    bus.timeout_i = 1'b1;
    step();
    chk("nom_drain_iso", bus.isolate_o, 1);
    chk("nom_drain_irq", irq, 1);
    chk("nom_drain_req", bus.rst_req_o, 0);
    bus.timeout_i = 1'b0;
    step();
    chk("nom_a0_req", bus.rst_req_o, 1);
    chk("nom_a0_irq", irq, 0);
    step();
    bus.rst_stat_i = 1'b1;
    chk("nom_a1_req", bus.rst_req_o, 1);
    step();
    step();
    chk("nom_a3_req", bus.rst_req_o, 1);
    step();
    chk("nom_rel_req", bus.rst_req_o, 0);
    chk("nom_rel_iso", bus.isolate_o, 1);
    step();
    step();
    bus.rst_stat_i = 1'b0;
    chk("nom_rel_clr", bus.guard_clr_o, 0);
    step();
    chk("nom_clr_pulse", bus.guard_clr_o, 1);
    chk("nom_clr_evt", evt_cnt, 0);
    step();
    chk("nom_idle_clr", bus.guard_clr_o, 0);
    chk("nom_idle_busy", busy, 0);
    chk("nom_idle_iso", bus.isolate_o, 0);
    chk("nom_evt", evt_cnt, 1);
    chk("nom_irq_count", irq_cnt - irq0, 1);

    // Forced drain
    cfg_lim = 6;
    cfg_hold = 1;
    bus.idle_i = 1'b0;
    step();
    bus.timeout_i = 1'b1;
    step();
    bus.timeout_i = 1'b0;
    chk("fd_entry_iso", bus.isolate_o, 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("fd_wait_req", bus.rst_req_o, 0);
      chk("fd_wait_iso", bus.isolate_o, 1);
    end
    step();
    chk("fd_assert_req", bus.rst_req_o, 1);
    bus.idle_i = 1'b1;
    bus.rst_stat_i = 1'b1;
    step();
    chk("fd_hold1_release", bus.rst_req_o, 0);
    bus.rst_stat_i = 1'b0;
    step();
    chk("fd_clr", bus.guard_clr_o, 1);
    step();
    chk("fd_evt", evt_cnt, 2);

    // No reset acknowledge
    cfg_lim = 10;
    cfg_hold = 4;
    step();
    bus.timeout_i = 1'b1;
    step();
    bus.timeout_i = 1'b0;
    step();
    chk("na_a0_req", bus.rst_req_o, 1);
    irq0 = irq_cnt;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("na_wait_req", bus.rst_req_o, 1);
      chk("na_wait_fault", fault, 0);
    end
    step();
    chk("na_fault", fault, 1);
    chk("na_fault_irq", irq, 1);
    chk("na_fault_req", bus.rst_req_o, 0);
    chk("na_fault_iso", bus.isolate_o, 1);
    chk("na_fault_evt", evt_cnt, 2);
    step();
    chk("na_irq_once", irq, 0);
    chk("na_sticky", fault, 1);
    chk("na_irq_count", irq_cnt - irq0, 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("na_clr_busy", busy, 0);
    chk("na_clr_fault", fault, 0);
    chk("na_clr_iso", bus.isolate_o, 0);
    chk("na_clr_irq", irq, 0);
    chk("na_clr_gclr", bus.guard_clr_o, 0);
    chk("na_clr_evt", evt_cnt, 2);

    // Held timeout
    cfg_lim = 20;
    cfg_hold = 1;
    step();
    bus.timeout_i = 1'b1;
    step();
    chk("ht_drain", busy, 1);
    step();
    bus.rst_stat_i = 1'b1;
    step();
    bus.rst_stat_i = 1'b0;
    step();
    step();
    chk("ht_evt_sat", evt_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ht_no_retrig", busy, 0);
    end
    bus.timeout_i = 1'b0;
    step();
    chk("ht_low_idle", busy, 0);
    bus.timeout_i = 1'b1;
    step();
    chk("ht_retrig", busy, 1);

    // Reset in the second ASSERT cycle
    step();
    chk("rm_a0_req", bus.rst_req_o, 1);
    step();
    chk("rm_a1_req", bus.rst_req_o, 1);
    #1 rst = 1'b1;
    #1;
    chk("rm_async_req", bus.rst_req_o, 0);
    chk("rm_async_iso", bus.isolate_o, 0);
    chk("rm_async_busy", busy, 0);
    chk("rm_async_evt", evt_cnt, 0);
    step();
    rst = 1'b0;
    bus.timeout_i = 1'b0;
    run_recovery();
    chk("rm_fresh_evt", evt_cnt, 1);
    chk("rm_fresh_idle", busy, 0);

    // Saturation with zero hold
    cfg_hold = 0;
    for (int k = 0; k < 5; k++) begin
      run_recovery();
      chk("sat_evt", evt_cnt, (k == 0) ? 2 : 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
